// File: rtl/serial_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pattern_pkg
// Description : Shared state encoding and effective-length helper for the
//               serial pattern transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } state_e;

    // A length of 0, or one longer than the pattern register, means "full width".
    function automatic logic [31:0] eff_len(input logic [31:0] len, input logic [31:0] width);
        return ((len == 32'd0) || (len > width)) ? width : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/down_counter.sv
`default_nettype none
// ============================================================================
// Module      : down_counter
// Description : Loadable saturating down-counter with zero flag and
//               synchronous clear; exposes its next value for look-ahead.
// Revision    : 1.0 - initial release
// ============================================================================
module down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count_next,
    output logic         o_zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (i_load) begin
            count_d = i_load_val;
        end else if (i_dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign o_count_next = count_d;
    assign o_zero       = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_pattern_tx
// Description : Captures a pattern, length and repeat count, then shifts the
//               pattern out MSB-first on x with one idle gap between repeats.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);
    import serial_pattern_pkg::*;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LEN_W-1:0] w_len_eff;
    logic             w_idx_load, w_idx_dec, w_idx_zero;
    logic [LEN_W-1:0] w_idx_load_val, w_idx_next;
    logic             w_rep_load, w_rep_dec, w_rep_zero;
    logic [REP_W-1:0] w_rep_next_unused;
    logic [WIDTH-1:0] w_shifted;

    assign w_len_eff = LEN_W'(eff_len(32'(len), 32'(WIDTH)));

    down_counter #(.W(LEN_W)) u_idx (
        .clk          (clk),
        .clr          (clr),
        .i_load       (w_idx_load),
        .i_load_val   (w_idx_load_val),
        .i_dec        (w_idx_dec),
        .o_count_next (w_idx_next),
        .o_zero       (w_idx_zero)
    );

    down_counter #(.W(REP_W)) u_rep (
        .clk          (clk),
        .clr          (clr),
        .i_load       (w_rep_load),
        .i_load_val   (reps),
        .i_dec        (w_rep_dec),
        .o_count_next (w_rep_next_unused),
        .o_zero       (w_rep_zero)
    );

    always_comb begin
        state_d        = state_q;
        pat_d          = pat_q;
        len_d          = len_q;
        w_idx_load     = 1'b0;
        w_idx_load_val = len_q - LEN_W'(1);
        w_idx_dec      = 1'b0;
        w_rep_load     = 1'b0;
        w_rep_dec      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d        = SEND;
                    pat_d          = pattern;
                    len_d          = w_len_eff;
                    w_idx_load     = 1'b1;
                    w_idx_load_val = w_len_eff - LEN_W'(1);
                    w_rep_load     = 1'b1;
                end
            end
            SEND: begin
                if (!w_idx_zero) begin
                    w_idx_dec = 1'b1;
                end else if (!w_rep_zero) begin
                    state_d    = GAP;
                    w_rep_dec  = 1'b1;
                    w_idx_load = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            GAP:  state_d = SEND;
            DONE: state_d = IDLE;
        endcase

        // Outputs are registered from the next state and next index so they
        // line up with the state they describe.
        w_shifted = pat_d >> w_idx_next;
        x_valid_d = (state_d == SEND);
        x_d       = x_valid_d & w_shifted[0];
        busy_d    = (state_d == SEND) || (state_d == GAP);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial pattern transmitter: the driving end of the single-bit serial stream that the team's sequence-recognizer FSMs consume. It captures a parallel pattern, a bit length and a repeat count, then shifts the pattern out MSB-first on `x`, one bit per clock, for the requested number of repetitions. The block feeds recognizer benches and on-board demos, so one generator can exercise any recognizer with exact, repeatable bit streams.

## Interface
Parameters:
- `WIDTH`, 8: maximum pattern length in bits.
- `LEN_W`, 4: width of `len`; must satisfy 2^LEN_W > WIDTH.
- `REP_W`, 4: width of `reps`.

Ports:
- `clk`  in  1  system clock. All state changes on the rising edge.
- `clr`  in  1  reset, synchronous and active-high.
- `start`  in  1  request a transmission. Sampled only in IDLE.
- `pattern`  in  WIDTH  bits to send. Bit `len-1` goes out first, bit 0 last.
- `len`  in  LEN_W  number of bits per repetition. 0 or any value >WIDTH is treated as WIDTH.
- `reps`  in  REP_W  extra repetitions. The pattern is sent `reps+1` times.
- `x`  out  1  serial data. 0 whenever `x_valid`=0.
- `x_valid`  out  1  `x` carries a pattern bit this cycle.
- `busy`  out  1  high in SEND and GAP.
- `done`  out  1  one-cycle pulse after the last bit.

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - On `start`=1, capture `pattern`, the effective length L, and `reps` into internal registers, then go to SEND.
  - The bit index is set to L-1.
  - The repeat counter is set to `reps`.
- SEND:
  - `x` = captured `pattern[index]`, `x_valid`=1.
  - If index≠0, decrement the index.
  - If index=0 and the repeat counter≠0, go to GAP, decrement the repeat counter and reload the index to L-1.
  - If index=0 and the repeat counter=0, go to DONE.
- GAP:
  - One idle cycle between repetitions: `x`=0, `x_valid`=0, `busy`=1.
  - Always goes to SEND.
- DONE:
  - `done`=1, `busy`=0, `x_valid`=0 for exactly one cycle.
  - Always goes to IDLE.
  - `start` is ignored in this state.
- Input changes:
  - `start` is ignored outside IDLE.
  - Changes on `pattern`, `len` or `reps` after capture have no effect.
- Arithmetic:
  - The index is LEN_W bits and counts down only; it never wraps.
  - The repeat counter is REP_W bits and counts down only.
  - `reps` = all-ones sends 2^REP_W repetitions.
- All outputs are registered Moore outputs, decoded from the state and the captured registers only. There is no combinational path from inputs to outputs.

## Timing
- Reset:
  - `clr`=1 at a rising edge puts the block in IDLE.
  - `x`, `x_valid`, `busy` and `done` read 0 from that edge on.
  - Index, repeat counter and captured pattern clear to 0.
- `clr` mid-transmission aborts immediately. No `done` pulse is produced.
- `clr` and `start` at the same edge: `clr` wins, and the block stays in IDLE.
- Latency: with `start` sampled at edge N, the first bit is valid in the cycle after edge N.
- Transmission length: one transmission occupies (reps+1)·L + reps cycles of busy, plus 1 DONE cycle.
- Back-to-back requests: the earliest next `start` acceptance is the edge that leaves IDLE, one cycle after DONE. The minimum inter-transmission gap is therefore 2 cycles with `x_valid`=0.
- `x` changes only on rising edges. The consumer samples `x` on the next rising edge, or on the falling edge mid-cycle.

## Structure
- Shared package `serial_pattern_pkg`:
  - 2-bit state encoding constants: IDLE=00, SEND=01, GAP=10, DONE=11.
  - Function computing the effective length, which maps 0 or >WIDTH to WIDTH.
- One natural sub-module, `down_counter`: a parameterised-width loadable down-counter with a zero flag and synchronous clear. It is instantiated twice, once for the bit index and once for the repeat counter.
- The FSM, capture registers and output decode live in `serial_pattern_tx`.

## Test plan
- Reset mid-SEND: `pattern`=8'hA5, `len`=8, `reps`=0, assert `clr` at the 3rd bit.
  - Next edge: all outputs 0, no `done`.
  - A subsequent `start` runs normally.
- Single shot: `pattern`=8'b1011_0010, `len`=8, `reps`=0.
  - `x` = 1,0,1,1,0,0,1,0 with `x_valid`=1 for 8 cycles.
  - Then `done`=1 for 1 cycle; `busy`=1 for exactly 8 cycles.
- Repeats with gap: `pattern`=8'h02, `len`=2 (sends 1,0), `reps`=2.
  - Valid stream: 1,0,gap,1,0,gap,1,0.
  - `busy` is 8 cycles, then `done`.
- Length edge cases:
  - `len`=0 with `pattern`=8'hFF gives 8 ones.
  - `len`=1 with `pattern` bit0=1 gives a single 1 and `done` on the 2nd cycle.
  - `len`=15 is treated as 8.
- Input ignoring:
  - `start` held high throughout: a new transmission begins only one cycle after each DONE.
  - `pattern` changed mid-SEND: output is unaffected.
- Loopback: drive `x` into a recognizer instance with `len`=2, `pattern`=2'b01, `reps`=0.
  - The recognizer output asserts on the expected cycle.
  - `clr`+`start` at the same edge produces no transmission.
